crc32_frame_checker: RTL and testbench
======================================

Name: crc32_frame_checker

Overview:
Sequential CRC-32 accumulator and checker for word-aligned frames arriving on a 32-bit valid/ready stream. It holds the running CRC state in a register and folds one word per accepted beat through the combinational crc32 step (reflected polynomial 0xEDB88320, data[7:0] is the first byte on the wire). On the last beat it compares the received FCS word against the computed CRC and presents a held result record to the downstream frame-status consumer.

Parameters:
MAX_WORDS, 1024, maximum payload words per frame (FCS word excluded); any beyond this set lenErr.
CNT_W, 16, width of the payload word counter and of the result length field; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
clk  input  1  sole clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
inValid  input  1  input beat valid.
inReady  output  1  input beat accepted when inValid && inReady.
inData  input  32  payload word, or the FCS word on the eof beat.
inSof  input  1  first beat of a frame.
inEof  input  1  last beat of a frame; inData carries the FCS.
resValid  output  1  result record valid; held until accepted.
resReady  input  1  result accepted when resValid && resReady.
resOk  output  1  FCS matched, and no length or abort error.
resLenErr  output  1  payload exceeded MAX_WORDS.
resAbort  output  1  frame was terminated by a new inSof before its eof.
resCrc  output  32  computed CRC, i.e. ~crcReg at the eof beat.
resLen  output  CNT_W  payload words counted, saturating at 2^CNT_W-1.

Behaviour:
- Reset (asynchronous assert, synchronous release) puts the block in IDLE: crcReg=32'hFFFFFFFF, count=0, resValid=0, all res* fields 0. inReady=1 in the first cycle after release.
- inReady is 1 in IDLE and ACCUM and 0 in RESULT. It is a combinational decode of state only; there is no path from inValid to inReady.
- IDLE:
  - Accepted beat with inSof && !inEof: crcReg <= crc32(FFFFFFFF, inData), count <= 1, go to ACCUM.
  - Accepted beat with inSof && inEof (single-word frame, empty payload): compare 32'h0 == inData, count = 0, go to RESULT.
  - Accepted beat with !inSof: discarded; state is unchanged.
- ACCUM:
  - Accepted beat with !inSof && !inEof: crcReg <= crc32(crcReg, inData), count++ (saturating). If count reaches MAX_WORDS, set a sticky lenErr.
  - Accepted beat with !inSof && inEof: ok = (~crcReg == inData) && !lenErr. Latch resCrc=~crcReg, resLen=count, resLenErr. Go to RESULT.
  - Accepted beat with inSof (with or without inEof): the old frame is aborted. Latch resAbort=1, resOk=0, resCrc=~crcReg, resLen=count, go to RESULT. The new sof beat is consumed and dropped; the source must resend that frame.
- RESULT: resValid=1 and all res* fields stable. On resReady, go to IDLE, reset crcReg=FFFFFFFF, count=0 and lenErr=0, and set resValid=0 next cycle. This gives a minimum one-cycle bubble between frames.
- Latency: resValid rises in the cycle after the eof beat is accepted. Throughput is one word per cycle within a frame.
- The FCS word never enters crcReg.
- No combinational path from inData to any output.

Optional Feature:
CRC32_FRAME_CHECKER_STATS_EN.
- Defined: adds outputs statFrames[31:0], statBadFcs[31:0] and statAborts[31:0].
  - statFrames increments on each resValid && resReady handshake.
  - statBadFcs increments when that result has resOk=0 with no abort.
  - statAborts increments when that result has resAbort=1.
  - All three wrap modulo 2^32 and reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package crc32_pkg: CRC32_INIT=32'hFFFFFFFF, CRC32_POLY=32'hEDB88320, state enum {IDLE, ACCUM, RESULT}, and a packed result struct {ok, lenErr, abort, crc, len}.
- Instantiate the existing crc32 combinational step exactly once, with crcIn=(state==IDLE ? CRC32_INIT : crcReg) and data=inData.
- No other sub-module.

Test Plan:
- Frame: sof word 32'h34333231 ("1234"), then eof with FCS 32'h9BE3E0A3 -> resValid 1 cycle later with resOk=1, resCrc=32'h9BE3E0A3, resLen=1.
- Same frame with FCS 32'h9BE3E0A2 -> resOk=0, resCrc=32'h9BE3E0A3, no lenErr or abort.
- Single beat with sof=eof=1 and inData=0 -> resOk=1, resLen=0; repeating with inData=1 -> resOk=0.
- Hold resReady=0 for 10 cycles while inValid stays 1 -> inReady=0 throughout and res* stable; then resReady=1 -> IDLE, and the next frame is accepted one cycle later.
- MAX_WORDS=4 with 5 payload words plus a correct FCS -> resLenErr=1, resOk=0, resLen=5.
- sof plus 2 words, then a new sof -> resAbort=1, resLen=3. Assert rst_n=0 mid-frame -> resValid=0 and inReady=1 after release; a following clean frame passes.

Source files
------------

// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - shared CRC-32 constants, checker state and result record
package crc32_pkg;

  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;

  // Width of the length field carried in the result record.
  localparam int CRC32_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } crc32State_t;

  typedef struct packed {
    logic                   ok;
    logic                   lenErr;
    logic                   abort;
    logic [31:0]            crc;
    logic [CRC32_CNT_W-1:0] len;
  } crc32Result_t;

endpackage

// File: rtl/crc32.sv
// rtl/crc32.sv - combinational one-word reflected CRC-32 step, data[7:0] first
module crc32
  import crc32_pkg::*;
(
  input  logic [31:0] crcIn,
  input  logic [31:0] data,
  output logic [31:0] crcOut
);

  // Fold 32 data bits LSB-first; byte 0 is the low byte, each byte LSB-first.
  always_comb begin
    logic [31:0] c;
    c = crcIn ^ data;
    for (int i = 0; i < 32; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crcOut = c;
  end

endmodule

// File: rtl/crc32_frame_checker.sv
// rtl/crc32_frame_checker.sv - CRC-32 frame accumulator/checker; optional CRC32_FRAME_CHECKER_STATS_EN counters
module crc32_frame_checker
  import crc32_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [31:0]      inData,
  input  logic             inSof,
  input  logic             inEof,
  output logic             resValid,
  input  logic             resReady,
  output logic             resOk,
  output logic             resLenErr,
  output logic             resAbort,
  output logic [31:0]      resCrc,
  output logic [CNT_W-1:0] resLen
`ifdef CRC32_FRAME_CHECKER_STATS_EN
  ,
  output logic [31:0]      statFrames,
  output logic [31:0]      statBadFcs,
  output logic [31:0]      statAborts
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] SAT_CNT = '1;

  crc32State_t      state;
  logic [31:0]      crcReg;
  logic [CNT_W-1:0] count;
  logic             lenErr;
  crc32Result_t     res;

  logic [31:0]      crcSel;
  logic [31:0]      crcNext;
  logic             accepted;
  logic             fcsMatch;
  logic [CNT_W-1:0] countInc;

  // A new frame always seeds from the init value, so IDLE bypasses crcReg.
  assign crcSel   = (state == IDLE) ? CRC32_INIT : crcReg;
  assign inReady  = (state != RESULT);
  assign accepted = inValid && inReady;
  assign fcsMatch = (~crcSel == inData);
  assign countInc = (count == SAT_CNT) ? count : count + 1'b1;

  crc32 uStep (
    .crcIn  (crcSel),
    .data   (inData),
    .crcOut (crcNext)
  );

  // Frame state machine: accumulate payload, judge the FCS, hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crcReg   <= CRC32_INIT;
      count    <= '0;
      lenErr   <= 1'b0;
      resValid <= 1'b0;
      res      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accepted && inSof) begin
            if (inEof) begin
              res <= '{ok: fcsMatch, lenErr: 1'b0, abort: 1'b0,
                       crc: ~crcSel, len: '0};
              resValid <= 1'b1;
              state    <= RESULT;
            end else begin
              crcReg <= crcNext;
              count  <= CNT_W'(1);
              lenErr <= 1'b0;
              state  <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accepted) begin
            if (inSof) begin
              // The interrupting sof beat is dropped; only the old frame is reported.
              res <= '{ok: 1'b0, lenErr: lenErr, abort: 1'b1,
                       crc: ~crcReg, len: CRC32_CNT_W'(count)};
              resValid <= 1'b1;
              state    <= RESULT;
            end else if (inEof) begin
              res <= '{ok: fcsMatch && !lenErr, lenErr: lenErr, abort: 1'b0,
                       crc: ~crcReg, len: CRC32_CNT_W'(count)};
              resValid <= 1'b1;
              state    <= RESULT;
            end else begin
              crcReg <= crcNext;
              count  <= countInc;
              if (count >= MAX_CNT) begin
                lenErr <= 1'b1;
              end
            end
          end
        end
        RESULT: begin
          if (resReady) begin
            resValid <= 1'b0;
            crcReg   <= CRC32_INIT;
            count    <= '0;
            lenErr   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resOk     = res.ok;
  assign resLenErr = res.lenErr;
  assign resAbort  = res.abort;
  assign resCrc    = res.crc;
  assign resLen    = CNT_W'(res.len);

`ifdef CRC32_FRAME_CHECKER_STATS_EN
  // Count delivered results by outcome; counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statFrames <= '0;
      statBadFcs <= '0;
      statAborts <= '0;
    end else if (resValid && resReady) begin
      statFrames <= statFrames + 1'b1;
      if (res.abort) begin
        statAborts <= statAborts + 1'b1;
      end else if (!res.ok) begin
        statBadFcs <= statBadFcs + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_crc32_frame_checker.sv
// tb/tb_crc32_frame_checker.sv - directed self-checking bench for crc32_frame_checker
module tb_crc32_frame_checker;

  localparam int MAXW = 4;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [31:0]   inData = '0;
  logic          inSof = 1'b0;
  logic          inEof = 1'b0;
  logic          resValid;
  logic          resReady = 1'b0;
  logic          resOk;
  logic          resLenErr;
  logic          resAbort;
  logic [31:0]   resCrc;
  logic [CW-1:0] resLen;
`ifdef CRC32_FRAME_CHECKER_STATS_EN
  logic [31:0]   statFrames;
  logic [31:0]   statBadFcs;
  logic [31:0]   statAborts;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] payload[$];
  logic [31:0] expCrc;

  crc32_frame_checker #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inValid   (inValid),
    .inReady   (inReady),
    .inData    (inData),
    .inSof     (inSof),
    .inEof     (inEof),
    .resValid  (resValid),
    .resReady  (resReady),
    .resOk     (resOk),
    .resLenErr (resLenErr),
    .resAbort  (resAbort),
    .resCrc    (resCrc),
    .resLen    (resLen)
`ifdef CRC32_FRAME_CHECKER_STATS_EN
    ,
    .statFrames(statFrames),
    .statBadFcs(statBadFcs),
    .statAborts(statAborts)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference CRC: byte by byte, each byte LSB-first.
  function automatic logic [31:0] refStep(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    logic [7:0]  b;
    r = c;
    for (int k = 0; k < 4; k++) begin
      b = w[8*k +: 8];
      r = r ^ {24'h0, b};
      for (int j = 0; j < 8; j++) begin
        if (r[0]) r = (r >> 1) ^ 32'hEDB88320;
        else      r = r >> 1;
      end
    end
    return r;
  endfunction

  // Starts and ends at a falling edge.
  task automatic sendBeat(input logic [31:0] d, input logic s, input logic e);
    int n;
    inValid = 1'b1; inData = d; inSof = s; inEof = e;
    n = 0;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) checkVal("beat_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0; inSof = 1'b0; inEof = 1'b0;
  endtask

  // Sends the payload queue, computes the expected CRC into expCrc.
  task automatic sendPayload();
    expCrc = 32'hFFFFFFFF;
    for (int i = 0; i < payload.size(); i++) begin
      expCrc = refStep(expCrc, payload[i]);
      sendBeat(payload[i], i == 0, 1'b0);
    end
    expCrc = ~expCrc;
  endtask

  task automatic ackResult(input string tag);
    checkVal({tag, "_valid"}, {31'h0, resValid}, 32'd1);
    resReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resReady = 1'b0;
    checkVal({tag, "_validLow"}, {31'h0, resValid}, 32'd0);
    checkVal({tag, "_readyBack"}, {31'h0, inReady}, 32'd1);
  endtask

  task automatic checkRes(input string tag, input logic ok, input logic le, input logic ab,
                          input logic [31:0] crc, input logic [31:0] len);
    checkVal({tag, "_latency"}, {31'h0, resValid}, 32'd1);
    checkVal({tag, "_ok"}, {31'h0, resOk}, {31'h0, ok});
    checkVal({tag, "_lenErr"}, {31'h0, resLenErr}, {31'h0, le});
    checkVal({tag, "_abort"}, {31'h0, resAbort}, {31'h0, ab});
    checkVal({tag, "_crc"}, resCrc, crc);
    checkVal({tag, "_len"}, {16'h0, resLen}, len);
  endtask

  initial begin
    #3;
    checkVal("rst_valid", {31'h0, resValid}, 32'd0);
    checkVal("rst_ready", {31'h0, inReady}, 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("rel_ready", {31'h0, inReady}, 32'd1);
    checkVal("rel_ok", {31'h0, resOk}, 32'd0);
    checkVal("rel_crc", resCrc, 32'd0);
    checkVal("rel_len", {16'h0, resLen}, 32'd0);

    // "1234" with good FCS
    sendBeat(32'h34333231, 1'b1, 1'b0);
    sendBeat(32'h9BE3E0A3, 1'b0, 1'b1);
    checkRes("good", 1'b1, 1'b0, 1'b0, 32'h9BE3E0A3, 32'd1);
    ackResult("good");

    // Same frame, FCS off by one bit
    sendBeat(32'h34333231, 1'b1, 1'b0);
    sendBeat(32'h9BE3E0A2, 1'b0, 1'b1);
    checkRes("badfcs", 1'b0, 1'b0, 1'b0, 32'h9BE3E0A3, 32'd1);
    ackResult("badfcs");

    // Empty payload frames
    sendBeat(32'h0, 1'b1, 1'b1);
    checkRes("empty0", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
    ackResult("empty0");
    sendBeat(32'h1, 1'b1, 1'b1);
    checkRes("empty1", 1'b0, 1'b0, 1'b0, 32'h0, 32'd0);
    ackResult("empty1");

    // Back-pressure on the result while the source keeps offering a frame
    sendBeat(32'h34333231, 1'b1, 1'b0);
    sendBeat(32'h9BE3E0A3, 1'b0, 1'b1);
    inValid = 1'b1; inSof = 1'b1; inEof = 1'b1; inData = 32'h0;
    for (int i = 0; i < 10; i++) begin
      checkVal("hold_ready", {31'h0, inReady}, 32'd0);
      checkVal("hold_crc", resCrc, 32'h9BE3E0A3);
      checkVal("hold_ok", {31'h0, resOk}, 32'd1);
      @(negedge clk);
    end
    resReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resReady = 1'b0;
    checkVal("hold_validLow", {31'h0, resValid}, 32'd0);
    checkVal("hold_readyBack", {31'h0, inReady}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0; inSof = 1'b0; inEof = 1'b0;
    checkRes("after_hold", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
    ackResult("after_hold");

    // Five payload words exceed MAX_WORDS=4
    payload = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    sendPayload();
    sendBeat(expCrc, 1'b0, 1'b1);
    checkRes("len5", 1'b0, 1'b1, 1'b0, expCrc, 32'd5);
    ackResult("len5");

    // Exactly MAX_WORDS words is legal
    payload = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    sendPayload();
    sendBeat(expCrc, 1'b0, 1'b1);
    checkRes("len4", 1'b1, 1'b0, 1'b0, expCrc, 32'd4);
    ackResult("len4");

    // Abort by a new sof after three payload words
    payload = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00FF00FF};
    sendPayload();
    sendBeat(32'h12345678, 1'b1, 1'b0);
    checkRes("abort", 1'b0, 1'b0, 1'b1, expCrc, 32'd3);
`ifdef CRC32_FRAME_CHECKER_STATS_EN
    resReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resReady = 1'b0;
    checkVal("statFrames", statFrames, 32'd9);
    checkVal("statBadFcs", statBadFcs, 32'd3);
    checkVal("statAborts", statAborts, 32'd1);
`else
    ackResult("abort");
`endif

    // Reset mid-frame
    sendBeat(32'h34333231, 1'b1, 1'b0);
    sendBeat(32'h77777777, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkVal("midrst_valid", {31'h0, resValid}, 32'd0);
    checkVal("midrst_ready", {31'h0, inReady}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("postrst_ready", {31'h0, inReady}, 32'd1);
    checkVal("postrst_valid", {31'h0, resValid}, 32'd0);
    sendBeat(32'h34333231, 1'b1, 1'b0);
    sendBeat(32'h9BE3E0A3, 1'b0, 1'b1);
    checkRes("postrst", 1'b1, 1'b0, 1'b0, 32'h9BE3E0A3, 32'd1);
    ackResult("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
